// File: rtl/board_port_scheduler_if.sv
// Engine request port and single-port board memory port shared by the scheduler.
// Engine handshake: an access is taken in every cycle where eng_req_in and eng_ack_out are both high.
// eng_addr_in, eng_we_in and eng_wdata_in must be valid in that cycle. Reads return in order on eng_rvalid_out.
interface board_port_scheduler_if #(
  parameter int LOG_BOARD_SIZE = 9
);
  localparam int AW = 2 * LOG_BOARD_SIZE;

  logic          eng_req_in;
  logic          eng_we_in;
  logic [AW-1:0] eng_addr_in;
  logic          eng_wdata_in;
  logic          eng_ack_out;
  logic          eng_rvalid_out;
  logic          eng_rdata_out;

  logic [AW-1:0] mem_addr_out;
  logic          mem_we_out;
  logic          mem_wdata_out;
  logic          mem_rdata_in;

  // Scheduler side: serves the engine and drives the memory.
  modport master (
    input  eng_req_in, eng_we_in, eng_addr_in, eng_wdata_in, mem_rdata_in,
    output eng_ack_out, eng_rvalid_out, eng_rdata_out,
    output mem_addr_out, mem_we_out, mem_wdata_out
  );

  // Environment side: the update engine plus the board memory.
  modport slave (
    output eng_req_in, eng_we_in, eng_addr_in, eng_wdata_in, mem_rdata_in,
    input  eng_ack_out, eng_rvalid_out, eng_rdata_out,
    input  mem_addr_out, mem_we_out, mem_wdata_out
  );
endinterface

// File: rtl/board_port_scheduler.sv
// Shares the board memory between display fetches (absolute priority) and the update engine.
// The module also paces generation launches to frame boundaries.
module board_port_scheduler #(
  parameter int LOG_BOARD_SIZE = 9,
  parameter int MEM_LATENCY    = 2
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic [10:0]           hcount_in,
  input  logic [9:0]            vcount_in,
  input  logic                  run_in,
  input  logic                  step_in,
  input  logic [4:0]            period_in,
  output logic                  gen_start_out,
  input  logic                  gen_done_in,
  board_port_scheduler_if.master bus,
  output logic                  cell_alive_out,
  output logic                  busy_out,
  output logic [15:0]           gen_count_out,
  output logic                  overrun_out,
  output logic                  dbg_state_out
);

  localparam int          AW         = 2 * LOG_BOARD_SIZE;
  localparam int          BOARD_SIZE = 1 << LOG_BOARD_SIZE;
  localparam logic [10:0] H_LIMIT    = 11'(BOARD_SIZE);
  localparam logic [9:0]  V_LIMIT    = 10'(BOARD_SIZE);

  typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;
  typedef enum logic [1:0] {TAG_NONE = 2'd0, TAG_DISP = 2'd1, TAG_ENG_RD = 2'd2} tag_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic          r_step_pending;
  logic [4:0]    r_frame_cnt;
  logic [15:0]   r_gen_count;
  logic          r_overrun;
  logic [AW-1:0] r_mem_addr;
  logic          r_mem_we;
  logic          r_mem_wdata;
  tag_t          r_tag [MEM_LATENCY+1];
  logic          r_cell_alive;
  logic          r_eng_rvalid;
  logic          r_eng_rdata;

  logic          w_disp_slot;
  logic          w_fb;
  logic [4:0]    w_period_m1;
  logic          w_launch_ok;
  logic          w_launch;
  logic          w_eng_slot;
  logic          w_eng_ack;
  logic [AW-1:0] w_disp_addr;
  tag_t          w_tag_in;
  tag_t          w_tag_ret;

  assign w_disp_slot = (hcount_in < H_LIMIT) && (vcount_in < V_LIMIT);
  assign w_fb        = (hcount_in == 11'd0) && (vcount_in == V_LIMIT);
  assign w_disp_addr = {vcount_in[LOG_BOARD_SIZE-1:0], hcount_in[LOG_BOARD_SIZE-1:0]};
  assign w_period_m1 = (period_in == 5'd0) ? 5'd0 : period_in - 5'd1;
  assign w_launch_ok = r_step_pending || (run_in && (r_frame_cnt >= w_period_m1));
  assign w_launch    = (r_state == ST_IDLE) && w_fb && w_launch_ok;
  assign w_eng_ack   = bus.eng_req_in & w_eng_slot;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // done wins over a coincident frame boundary; the next launch waits for the following boundary
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_fb && w_launch_ok) w_state_nxt = ST_RUN;
      ST_RUN:  if (gen_done_in)         w_state_nxt = ST_IDLE;
      default:                          w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    gen_start_out = 1'b0;
    busy_out      = 1'b0;
    w_eng_slot    = 1'b0;
    case (r_state)
      ST_IDLE: gen_start_out = rst_n_in & w_fb & w_launch_ok;
      ST_RUN: begin
        busy_out   = 1'b1;
        w_eng_slot = ~w_disp_slot;
      end
      default: ;
    endcase
  end

  // A step that lands on the launch cycle stays pending for the next boundary.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_step_pending <= 1'b0;
      r_frame_cnt    <= 5'd0;
      r_gen_count    <= 16'd0;
      r_overrun      <= 1'b0;
    end else begin
      r_step_pending <= step_in | (r_step_pending & ~w_launch);
      if (w_launch) begin
        r_frame_cnt <= 5'd0;
      end else if ((r_state == ST_IDLE) && w_fb && (r_frame_cnt != 5'd31)) begin
        r_frame_cnt <= r_frame_cnt + 5'd1;
      end
      if ((r_state == ST_RUN) && gen_done_in) begin
        r_gen_count <= r_gen_count + 16'd1;
      end else if ((r_state == ST_RUN) && w_fb) begin
        r_overrun <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_mem_addr  <= '0;
      r_mem_we    <= 1'b0;
      r_mem_wdata <= 1'b0;
    end else if (w_disp_slot) begin
      r_mem_addr  <= w_disp_addr;
      r_mem_we    <= 1'b0;
      r_mem_wdata <= 1'b0;
    end else if (w_eng_ack) begin
      r_mem_addr  <= bus.eng_addr_in;
      r_mem_we    <= bus.eng_we_in;
      r_mem_wdata <= bus.eng_wdata_in;
    end else begin
      r_mem_we    <= 1'b0;
    end
  end

  always_comb begin
    w_tag_in = TAG_NONE;
    if (w_disp_slot) begin
      w_tag_in = TAG_DISP;
    end else if (w_eng_ack && !bus.eng_we_in) begin
      w_tag_in = TAG_ENG_RD;
    end
  end

  // Stage MEM_LATENCY lines up with the cycle in which mem_rdata_in is valid.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int i = 0; i <= MEM_LATENCY; i++) r_tag[i] <= TAG_NONE;
    end else begin
      r_tag[0] <= w_tag_in;
      for (int i = 1; i <= MEM_LATENCY; i++) r_tag[i] <= r_tag[i-1];
    end
  end

  assign w_tag_ret = r_tag[MEM_LATENCY];

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_cell_alive <= 1'b0;
      r_eng_rvalid <= 1'b0;
      r_eng_rdata  <= 1'b0;
    end else begin
      r_cell_alive <= (w_tag_ret == TAG_DISP) & bus.mem_rdata_in;
      r_eng_rvalid <= (w_tag_ret == TAG_ENG_RD);
      r_eng_rdata  <= (w_tag_ret == TAG_ENG_RD) & bus.mem_rdata_in;
    end
  end

  assign bus.eng_ack_out    = w_eng_ack;
  assign bus.eng_rvalid_out = r_eng_rvalid;
  assign bus.eng_rdata_out  = r_eng_rdata;
  assign bus.mem_addr_out   = r_mem_addr;
  assign bus.mem_we_out     = r_mem_we;
  assign bus.mem_wdata_out  = r_mem_wdata;
  assign cell_alive_out     = r_cell_alive;
  assign gen_count_out      = r_gen_count;
  assign overrun_out        = r_overrun;
  assign dbg_state_out      = r_state;

endmodule

// File: tb/tb_board_port_scheduler.sv
// Bench for board_port_scheduler: compressed video timing, behavioural board memory,
// an event-level scheduler model feeding expected queues, and a negedge monitor.
`timescale 1ns/1ps
module tb_board_port_scheduler;
  localparam int LOG      = 9;
  localparam int AW       = 2 * LOG;
  localparam int BS       = 1 << LOG;
  localparam int LAT      = 2;
  localparam int CELL_LAT = LAT + 2;

  // clock / reset
  logic        clk_in = 1'b0;
  logic        rst_n_in;
  always #5 clk_in = ~clk_in;

  logic [10:0] hcount_in;
  logic [9:0]  vcount_in;
  logic        run_in, step_in, gen_done_in;
  logic [4:0]  period_in;
  logic        gen_start_out, cell_alive_out, busy_out, overrun_out, dbg_state_out;
  logic [15:0] gen_count_out;

  board_port_scheduler_if #(.LOG_BOARD_SIZE(LOG)) bus ();

  board_port_scheduler #(.LOG_BOARD_SIZE(LOG), .MEM_LATENCY(LAT)) dut (
    .clk_in         (clk_in),
    .rst_n_in       (rst_n_in),
    .hcount_in      (hcount_in),
    .vcount_in      (vcount_in),
    .run_in         (run_in),
    .step_in        (step_in),
    .period_in      (period_in),
    .gen_start_out  (gen_start_out),
    .gen_done_in    (gen_done_in),
    .bus            (bus),
    .cell_alive_out (cell_alive_out),
    .busy_out       (busy_out),
    .gen_count_out  (gen_count_out),
    .overrun_out    (overrun_out),
    .dbg_state_out  (dbg_state_out)
  );

  // board memory: pattern x[0]^y[0] until written, two-cycle read latency
  bit   mem_wr_flag [0:(1<<AW)-1];
  bit   mem_wval    [0:(1<<AW)-1];
  int   wcount      [0:(1<<AW)-1];
  bit   count_en;
  logic rd_p1, rd_p2;

  function automatic logic pattern(input logic [AW-1:0] a);
    return a[0] ^ a[LOG];
  endfunction

  always @(posedge clk_in) begin
    rd_p1 <= mem_wr_flag[bus.mem_addr_out] ? mem_wval[bus.mem_addr_out] : pattern(bus.mem_addr_out);
    rd_p2 <= rd_p1;
    if (bus.mem_we_out) begin
      mem_wr_flag[bus.mem_addr_out] <= 1'b1;
      mem_wval[bus.mem_addr_out]    <= bus.mem_wdata_out;
      if (count_en) wcount[bus.mem_addr_out] <= wcount[bus.mem_addr_out] + 1;
    end
  end
  assign bus.mem_rdata_in = rd_p2;

  // reference board contents, updated when the model predicts an engine write
  bit ref_wr_flag [0:(1<<AW)-1];
  bit ref_wval    [0:(1<<AW)-1];
  function automatic logic ref_rd(input logic [AW-1:0] a);
    return ref_wr_flag[a] ? ref_wval[a] : pattern(a);
  endfunction

  // scoreboard
  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] exp_ack_q[$];
  logic [31:0] exp_cell_q[$];
  logic [31:0] exp_rd_q[$];
  logic [31:0] exp_start_q[$];
  logic [49:0] exp_wr_q[$];
  logic [48:0] exp_stat_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // scheduler model, kept at the level of frames and generations
  int  cyc = 0;
  bit  mon_en = 0;
  bit  m_run, m_step_pend, m_ovr;
  int  m_frames, m_gens, m_start_cyc;
  int  done_lat, step_at, eng_mode, wr_ctr;
  logic [AW-1:0] rd_list[$];

  task automatic model_reset();
    m_run = 0; m_step_pend = 0; m_ovr = 0; m_frames = 0; m_gens = 0; m_start_cyc = 0;
    step_at = -1;
    exp_ack_q.delete(); exp_cell_q.delete(); exp_rd_q.delete();
    exp_start_q.delete(); exp_wr_q.delete(); exp_stat_q.delete();
  endtask

  // driver: one pixel clock at (h, v)
  task automatic do_cycle(input int h, input int v);
    logic disp, fb, req, we, wd, ack, done, start, was_run;
    logic [AW-1:0] addr;
    int pm1;
    @(posedge clk_in); #1; cyc++;
    disp = (h < BS) && (v < BS);
    fb   = (h == 0) && (v == BS);
    req = 1'b0; we = 1'b0; wd = 1'b0; addr = '0;
    case (eng_mode)
      1: begin req = 1'b1; we = 1'b1; wd = 1'b1; addr = AW'(wr_ctr); end
      2: if (rd_list.size() > 0) begin req = 1'b1; addr = rd_list[0]; end
      3: begin
        req  = 1'($urandom_range(0, 1));
        we   = 1'($urandom_range(0, 1));
        wd   = 1'($urandom_range(0, 1));
        addr = AW'($urandom_range(0, (1 << AW) - 1));
      end
      default: ;
    endcase
    if (m_run) done = (done_lat > 0) && (cyc == m_start_cyc + done_lat);
    else       done = ($urandom_range(0, 63) == 0);
    hcount_in = 11'(h); vcount_in = 10'(v);
    step_in = (cyc == step_at); gen_done_in = done;
    bus.eng_req_in = req; bus.eng_we_in = we; bus.eng_addr_in = addr; bus.eng_wdata_in = wd;

    ack = req && !disp && m_run;
    exp_ack_q.push_back({31'(cyc), ack});
    if (disp) exp_cell_q.push_back({31'(cyc + CELL_LAT), ref_rd({v[LOG-1:0], h[LOG-1:0]})});
    else      exp_cell_q.push_back({31'(cyc + CELL_LAT), 1'b0});
    if (ack) begin
      if (we) begin
        ref_wr_flag[addr] = 1'b1; ref_wval[addr] = wd;
        exp_wr_q.push_back({31'(cyc + 1), addr, wd});
      end else begin
        exp_rd_q.push_back({31'(cyc + CELL_LAT), ref_rd(addr)});
      end
      if (eng_mode == 1) wr_ctr++;
      if (eng_mode == 2) void'(rd_list.pop_front());
    end

    pm1   = (period_in == 5'd0) ? 0 : int'(period_in) - 1;
    start = !m_run && fb && (m_step_pend || (run_in && m_frames >= pm1));
    if (start) exp_start_q.push_back(32'(cyc));
    if (fb) exp_stat_q.push_back({31'(cyc), m_run, m_ovr, 16'(m_gens)});
    was_run = m_run;
    if (start) begin
      m_step_pend = 0; m_frames = 0; m_run = 1; m_start_cyc = cyc;
    end else if (!was_run && fb) begin
      m_frames = (m_frames < 31) ? m_frames + 1 : 31;
    end
    if (was_run && done) begin
      m_gens++; m_run = 0;
    end else if (was_run && fb) begin
      m_ovr = 1;
    end
    if (step_in) m_step_pend = 1;
  endtask

  task automatic line(input int v, input int len);
    for (int h = 0; h < len; h++) do_cycle(h, v);
  endtask

  // compressed frame: one board line incl. hblank, the FB line, a vblank line
  task automatic frame(input int dv);
    line(dv, BS + 16);
    line(BS, 40);
    line(BS + 1, 200);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_gen_start"},  gen_start_out,      1'b0);
    chk({tag, "_rvalid"},     bus.eng_rvalid_out, 1'b0);
    chk({tag, "_rdata"},      bus.eng_rdata_out,  1'b0);
    chk({tag, "_mem_addr"},   bus.mem_addr_out,   '0);
    chk({tag, "_mem_we"},     bus.mem_we_out,     1'b0);
    chk({tag, "_mem_wdata"},  bus.mem_wdata_out,  1'b0);
    chk({tag, "_cell"},       cell_alive_out,     1'b0);
    chk({tag, "_busy"},       busy_out,           1'b0);
    chk({tag, "_gen_count"},  gen_count_out,      16'd0);
    chk({tag, "_overrun"},    overrun_out,        1'b0);
    chk({tag, "_state"},      dbg_state_out,      1'b0);
    chk({tag, "_ack"},        bus.eng_ack_out,    1'b0);
  endtask

  task automatic reset_mid_cycle();
    @(posedge clk_in); #3;
    rst_n_in = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    mon_en = 0;
    model_reset();
    step_in = 1'b0; gen_done_in = 1'b0; bus.eng_req_in = 1'b0;
    repeat (3) @(posedge clk_in);
    #1;
    rst_n_in = 1'b1;
    mon_en = 1;
  endtask

  // monitor
  always @(negedge clk_in) begin
    if (mon_en) begin
      if (exp_ack_q.size() > 0 && int'(exp_ack_q[0][31:1]) == cyc)
        chk("eng_ack", bus.eng_ack_out, exp_ack_q.pop_front() & 32'd1);
      if (exp_cell_q.size() > 0 && int'(exp_cell_q[0][31:1]) == cyc)
        chk("cell_alive", cell_alive_out, exp_cell_q.pop_front() & 32'd1);
      if (exp_stat_q.size() > 0 && int'(exp_stat_q[0][48:18]) == cyc) begin
        logic [48:0] e;
        e = exp_stat_q.pop_front();
        chk("fb_busy", busy_out, e[17]);
        chk("fb_overrun", overrun_out, e[16]);
        chk("fb_gen_count", gen_count_out, e[15:0]);
      end
      if (bus.eng_rvalid_out) begin
        if (exp_rd_q.size() == 0) chk("rvalid_unexpected", bus.eng_rvalid_out, 1'b0);
        else begin
          logic [31:0] e;
          e = exp_rd_q.pop_front();
          chk("rvalid_cycle", cyc, e[31:1]);
          chk("rdata", bus.eng_rdata_out, e[0]);
        end
      end
      if (exp_rd_q.size() > 0 && int'(exp_rd_q[0][31:1]) < cyc)
        chk("rvalid_missing_cycle", cyc, exp_rd_q.pop_front() >> 1);
      if (bus.mem_we_out) begin
        if (exp_wr_q.size() == 0) chk("mem_we_unexpected", bus.mem_we_out, 1'b0);
        else begin
          logic [49:0] e;
          e = exp_wr_q.pop_front();
          chk("wr_cycle", cyc, e[49:19]);
          chk("wr_addr", bus.mem_addr_out, e[18:1]);
          chk("wr_data", bus.mem_wdata_out, e[0]);
        end
      end
      if (exp_wr_q.size() > 0 && int'(exp_wr_q[0][49:19]) < cyc)
        chk("wr_missing_cycle", cyc, exp_wr_q.pop_front() >> 19);
      if (gen_start_out) begin
        if (exp_start_q.size() == 0) chk("gen_start_unexpected", gen_start_out, 1'b0);
        else chk("gen_start_cycle", cyc, exp_start_q.pop_front());
      end
      if (exp_start_q.size() > 0 && int'(exp_start_q[0]) < cyc)
        chk("gen_start_missing_cycle", cyc, exp_start_q.pop_front());
    end
  end

  // stimulus
  initial begin
    int bad, total;
    rst_n_in = 1'b0;
    hcount_in = 11'd600; vcount_in = 10'd600;
    run_in = 1'b0; step_in = 1'b0; period_in = 5'd0; gen_done_in = 1'b0;
    bus.eng_req_in = 1'b0; bus.eng_we_in = 1'b0; bus.eng_addr_in = '0; bus.eng_wdata_in = 1'b0;
    count_en = 0; eng_mode = 0; wr_ctr = 0; done_lat = 0;
    model_reset();
    #23;
    check_reset_outputs("por");
    #9;
    rst_n_in = 1'b1;
    mon_en = 1;

    // display sweep of line 5, idle engine
    frame(5);

    // step launch, engine write sweep under arbitration, overrun across FBs
    eng_mode = 1; count_en = 1;
    step_at = cyc + 100;
    frame(6);
    frame(7);
    frame(8);
    done_lat = cyc - m_start_cyc + 20;
    frame(9);
    eng_mode = 0;
    line(BS + 1, 20);
    count_en = 0;
    bad = 0; total = 0;
    for (int i = 0; i < 8192; i++) begin
      total += wcount[i];
      if (i < wr_ctr && wcount[i] != 1) bad++;
    end
    chk("write_once_bad_addrs", bad, 0);
    chk("write_total", total, wr_ctr);

    // engine reads of 7 and 8 back to back in vblank, then random traffic
    done_lat = 400;
    step_at = cyc + 50;
    frame(10);
    rd_list.push_back(AW'(7));
    rd_list.push_back(AW'(8));
    eng_mode = 2;
    line(BS + 1, 30);
    eng_mode = 3;
    line(BS + 1, 200);

    // run pacing: period 3, then period 0, then random
    run_in = 1'b1; period_in = 5'd3; done_lat = 600;
    repeat (7) frame($urandom_range(0, BS - 1));
    period_in = 5'd0; done_lat = 300;
    repeat (4) frame($urandom_range(0, BS - 1));
    repeat (4) begin
      period_in = 5'($urandom_range(0, 3));
      done_lat  = $urandom_range(100, 1500);
      if ($urandom_range(0, 1) == 1) step_at = cyc + $urandom_range(10, 400);
      repeat (2) frame($urandom_range(0, BS - 1));
    end

    // async reset mid-RUN
    period_in = 5'd0; done_lat = 0;
    frame(3);
    eng_mode = 0;
    line(3, 100);
    chk("busy_before_reset", busy_out, m_run);
    reset_mid_cycle();
    run_in = 1'b0;
    frame(4);
    frame(11);
    run_in = 1'b1; period_in = 5'd1; done_lat = 200;
    frame(12);
    frame(13);
    line(BS + 1, 20);

    chk("queues_drained", exp_rd_q.size() + exp_wr_q.size() + exp_start_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
